rle_decode: RTL and testbench

- Downstream expander for the 16-bit run-length stream produced by the capture-side RLE encoder.
- Word format:
  - bit15=0: literal sample in bits[14:0].
  - bit15=1: repeat count; bits[14:0] = additional copies of the last literal.
- Regenerates the uncompressed 15-bit sample stream, one sample per cycle, with backpressure.
- Sits between the SDRAM readback path and the trigger/upload logic, and serves as the loopback checker for the encoder.

---
 rtl/rle_pkg.sv | 19 +
 rtl/rle_decode.sv | 126 ++++++++++++
 tb/tb_rle_decode.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the RLE encoder/decoder pair: word layout and decoder FSM states.
package rle_pkg;

    localparam int unsigned RLE_DW       = 16;
    localparam int unsigned RLE_FLAG_BIT = 15;
    localparam int unsigned RLE_SW       = 15;

    // Encoded stream word: flag set means payload is a repeat count.
    typedef struct packed {
        logic              is_count;
        logic [RLE_SW-1:0] payload;
    } rle_word_t;

    typedef enum logic {
        IDLE   = 1'b0,
        REPEAT = 1'b1
    } rle_dec_state_e;

endpackage

// File: rtl/rle_decode.sv
// Run-length stream expander: literals pass through, count words replay the last literal.
// Optional transfer counters are enabled with RLE_DECODE_STATS_EN.
module rle_decode
    import rle_pkg::*;
#(
    parameter int unsigned DW = RLE_DW,
    parameter int unsigned SW = DW - 1
) (
    input  logic          core_clk,
    input  logic          core_rst_n,
    input  logic [DW-1:0] rle_data,
    input  logic          rle_valid,
    output logic          rle_ready,
    output logic [SW-1:0] dec_data,
    output logic          dec_valid,
    input  logic          dec_ready,
    output logic          busy
`ifdef RLE_DECODE_STATS_EN
    ,
    output logic [31:0]   stat_words,
    output logic [31:0]   stat_samples
`endif
);

    rle_dec_state_e state, state_nx;
    logic [SW-1:0]  rem, rem_nx;
    logic [SW-1:0]  last, last_nx;
    logic [SW-1:0]  data_nx;
    logic           valid_nx;
    rle_word_t      word;
    logic           out_free;
    logic           in_xfer;
    logic           out_xfer;

    assign word     = rle_word_t'(rle_data);
    assign out_free = !dec_valid || dec_ready;
    // Reset input gates ready so nothing is accepted while reset is held.
    assign rle_ready = core_rst_n && (state == IDLE) && out_free;
    assign in_xfer   = rle_valid && rle_ready;
    assign out_xfer  = dec_valid && dec_ready;
    assign busy      = (state == REPEAT) || dec_valid;

    // State and output register.
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            last      <= '0;
            dec_data  <= '0;
            dec_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            rem       <= rem_nx;
            last      <= last_nx;
            dec_data  <= data_nx;
            dec_valid <= valid_nx;
        end
    end

    // Next-state, repeat counter and output load.
    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        last_nx  = last;
        data_nx  = dec_data;
        valid_nx = dec_valid;

        if (out_free) begin
            valid_nx = 1'b0;
        end

        case (state)
            IDLE: begin
                if (in_xfer) begin
                    if (!word.is_count) begin
                        data_nx  = word.payload;
                        last_nx  = word.payload;
                        valid_nx = 1'b1;
                    end else if (word.payload != '0) begin
                        data_nx  = last;
                        valid_nx = 1'b1;
                        if (word.payload != SW'(1)) begin
                            rem_nx   = word.payload - SW'(1);
                            state_nx = REPEAT;
                        end
                    end
                end
            end
            REPEAT: begin
                // rem counts copies still to load; it is left at 1 on exit.
                if (out_free) begin
                    data_nx  = last;
                    valid_nx = 1'b1;
                    if (rem == SW'(1)) begin
                        state_nx = IDLE;
                    end else begin
                        rem_nx = rem - SW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

`ifdef RLE_DECODE_STATS_EN
    always_ff @(posedge core_clk) begin
        if (!core_rst_n) begin
            stat_words   <= '0;
            stat_samples <= '0;
        end else begin
            if (in_xfer) begin
                stat_words <= stat_words + 32'(1);
            end
            if (out_xfer) begin
                stat_samples <= stat_samples + 32'(1);
            end
        end
    end
`else
    logic unused_out_xfer;
    assign unused_out_xfer = out_xfer;
`endif

endmodule

// File: tb/tb_rle_decode.sv
// Self-checking bench for rle_decode: queue-based expansion model plus directed and random stimulus.
module tb_rle_decode;

    logic        core_clk;
    logic        core_rst_n;
    logic [15:0] rle_data;
    logic        rle_valid;
    logic        rle_ready;
    logic [14:0] dec_data;
    logic        dec_valid;
    logic        dec_ready;
    logic        busy;
`ifdef RLE_DECODE_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_samples;
`endif

    rle_decode dut (
        .core_clk    (core_clk),
        .core_rst_n  (core_rst_n),
        .rle_data    (rle_data),
        .rle_valid   (rle_valid),
        .rle_ready   (rle_ready),
        .dec_data    (dec_data),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .busy        (busy)
`ifdef RLE_DECODE_STATS_EN
        ,
        .stat_words  (stat_words),
        .stat_samples(stat_samples)
`endif
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    int checks = 0;
    int errors = 0;

    logic [14:0] exp_q[$];
    logic [14:0] out_log[$];
    int          acc_cyc[$];
    int          out_cyc[$];
    logic [14:0] mlast = '0;
    int          cyc = 0;
    int          n_acc = 0;
    int          n_words = 0;
    int          n_samps = 0;
    logic        held_v = 1'b0;
    logic [14:0] held_d = '0;

    logic        rdy_q[$];
    logic        rnd_rdy = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer ready: pattern queue first, then random or always-ready.
    always @(negedge core_clk) begin
        if (rdy_q.size() != 0) dec_ready = rdy_q.pop_front();
        else if (rnd_rdy)      dec_ready = ($urandom_range(0, 3) != 0);
        else                   dec_ready = 1'b1;
    end

    // Model: every accepted word appends its samples to exp_q; the DUT must drain it in order.
    always @(posedge core_clk) begin
        int sz;
        cyc++;
        if (!core_rst_n) begin
            chk("ready_in_reset", rle_ready, 0);
            exp_q.delete();
            mlast   = '0;
            held_v  = 1'b0;
            n_words = 0;
            n_samps = 0;
        end else begin
            sz = exp_q.size();
            chk("dec_valid", dec_valid, (sz != 0));
            chk("busy", busy, (sz != 0));
            chk("rle_ready", rle_ready, (sz <= 1) && (sz == 0 || dec_ready));
            if (held_v) chk("hold_data", dec_data, held_d);
            if (dec_valid && dec_ready) begin
                n_samps++;
                out_log.push_back(dec_data);
                out_cyc.push_back(cyc);
                if (sz == 0) chk("spurious_sample", 1, 0);
                else chk("sample", dec_data, exp_q.pop_front());
            end
            held_v = dec_valid && !dec_ready;
            held_d = dec_data;
            if (rle_valid && rle_ready) begin
                n_words++;
                n_acc++;
                acc_cyc.push_back(cyc);
                if (!rle_data[15]) begin
                    mlast = rle_data[14:0];
                    exp_q.push_back(mlast);
                end else begin
                    for (int i = 0; i < int'(rle_data[14:0]); i++) exp_q.push_back(mlast);
                end
            end
        end
    end

    task automatic clear_logs();
        out_log.delete();
        acc_cyc.delete();
        out_cyc.delete();
    endtask

    // Called at a negedge; returns at the negedge after the word is accepted.
    task automatic send(input logic [15:0] w);
        int s = n_acc;
        int t = 0;
        rle_valid = 1'b1;
        rle_data  = w;
        do begin
            @(negedge core_clk);
            t++;
        end while (n_acc == s && t < 2000);
        if (n_acc == s) chk("send_timeout", 0, 1);
        rle_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || busy) && t < 50000) begin
            @(negedge core_clk);
            t++;
        end
        if (t >= 50000) chk("idle_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        core_rst_n = 1'b0;
        @(negedge core_clk);
        core_rst_n = 1'b1;
    endtask

    initial begin
        int bad;
        core_rst_n = 1'b0;
        rle_valid  = 1'b1;
        rle_data   = 16'h0001;
        dec_ready  = 1'b1;

        // Reset held three cycles with a pending word.
        repeat (3) begin
            @(negedge core_clk);
            chk("rst_dec_valid", dec_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_rle_ready", rle_ready, 0);
        end
        core_rst_n = 1'b1;
        rle_valid  = 1'b0;
        @(negedge core_clk);

        // Literal stream, back to back.
        clear_logs();
        send(16'h0001);
        send(16'h0002);
        send(16'h7FFF);
        wait_idle();
        chk("lit_count", out_log.size(), 3);
        if (out_log.size() == 3) begin
            chk("lit0", out_log[0], 15'h0001);
            chk("lit1", out_log[1], 15'h0002);
            chk("lit2", out_log[2], 15'h7FFF);
            chk("lit_latency0", out_cyc[0] - acc_cyc[0], 1);
            chk("lit_latency2", out_cyc[2] - acc_cyc[2], 1);
            chk("lit_consecutive", acc_cyc[1] - acc_cyc[0], 1);
        end

        // Run expansion.
        clear_logs();
        send(16'h1234);
        send(16'h8003);
        send(16'h0005);
        wait_idle();
        chk("run_count", out_log.size(), 5);
        if (out_log.size() == 5) begin
            bad = 0;
            for (int i = 0; i < 4; i++) if (out_log[i] != 15'h1234) bad++;
            chk("run_values", bad, 0);
            chk("run_tail", out_log[4], 15'h0005);
            chk("run_ready_gap", acc_cyc[2] - acc_cyc[1], 3);
        end

        // Zero count emits nothing.
        clear_logs();
        send(16'h8000);
        repeat (3) @(negedge core_clk);
        chk("zero_count", out_log.size(), 0);

        // Count before any literal repeats zero.
        pulse_reset();
        clear_logs();
        send(16'h8000);
        send(16'h8002);
        wait_idle();
        chk("pre_lit_count", out_log.size(), 2);
        if (out_log.size() == 2) begin
            chk("pre_lit0", out_log[0], 0);
            chk("pre_lit1", out_log[1], 0);
        end

        // Maximum count.
        send(16'h00AA);
        wait_idle();
        clear_logs();
        send(16'hFFFF);
        wait_idle();
        chk("max_count", out_log.size(), 32767);
        bad = 0;
        foreach (out_log[i]) if (out_log[i] != 15'h00AA) bad++;
        chk("max_values", bad, 0);
        @(negedge core_clk);
        chk("max_busy_after", busy, 0);

        // Backpressure during a run.
        send(16'h0077);
        wait_idle();
        clear_logs();
        rdy_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        send(16'h8005);
        wait_idle();
        chk("bp_count", out_log.size(), 5);
        bad = 0;
        foreach (out_log[i]) if (out_log[i] != 15'h0077) bad++;
        chk("bp_values", bad, 0);

        // Reset in the middle of a run.
        send(16'h1111);
        wait_idle();
        clear_logs();
        send(16'h800A);
        begin
            int t = 0;
            while (out_log.size() < 2 && t < 100) begin
                @(negedge core_clk);
                t++;
            end
            chk("midrun_progress", (out_log.size() >= 2), 1);
        end
        pulse_reset();
        chk("midrun_dec_valid", dec_valid, 0);
        chk("midrun_busy", busy, 0);
        clear_logs();
        send(16'h8001);
        wait_idle();
        chk("midrun_after_count", out_log.size(), 1);
        if (out_log.size() == 1) chk("midrun_after_val", out_log[0], 0);

        // Random traffic with random backpressure.
        rnd_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            int r = $urandom_range(0, 99);
            if (r < 55)      send({1'b0, 15'($urandom)});
            else if (r < 95) send({1'b1, 15'($urandom_range(0, 5))});
            else             send({1'b1, 15'($urandom_range(6, 60))});
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge core_clk);
        end
        rnd_rdy = 1'b0;
        wait_idle();
        repeat (2) @(negedge core_clk);
        chk("final_drain", exp_q.size(), 0);

`ifdef RLE_DECODE_STATS_EN
        chk("stat_words", stat_words, n_words);
        chk("stat_samples", stat_samples, n_samps);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
